// File: rtl/ws2812b_bit_generator_if.sv
// ws2812b_bit_generator_if: symbol request/complete handshake and serial LED data between shifter and generator.
interface ws2812b_bit_generator_if;
  logic [1:0] genMode;
  logic       doGen;
  logic       genDone;
  logic       theBit;
  modport master (output genMode, doGen, input genDone, theBit);
  modport slave (input genMode, doGen, output genDone, theBit);
endinterface

// File: rtl/ws2812b_bit_generator.sv
// ws2812b_bit_generator: emits one WS2812B symbol ("0", "1", RET or blank) per period from registered outputs.
module ws2812b_bit_generator #(
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80,
  parameter int BIT_CYCLES = 125,
  parameter int RET_CYCLES = 5000
) (
  input logic clk,
  input logic reset,
  ws2812b_bit_generator_if.slave bus
);
  localparam int CW = $clog2(RET_CYCLES);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, RET} state_t;
  state_t state;
  logic [CW-1:0] cnt, nxt, len_m1, hi_len;
  logic [1:0] mode;
  logic start;
  always_comb begin
    len_m1 = state == RET ? CW'(RET_CYCLES - 1) : CW'(BIT_CYCLES - 1);
    hi_len = mode == 2'b11 ? CW'(T1H_CYCLES) : mode == 2'b10 ? CW'(T0H_CYCLES) : '0;
    nxt = cnt + 1'b1;
    start = bus.doGen && (state == IDLE || cnt == len_m1);
  end
  // Outputs are computed for the cycle after the edge, so they can leave straight from flops.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mode <= 2'b00;
      bus.theBit <= 1'b0;
      bus.genDone <= 1'b0;
    end else if (start) begin
      mode <= bus.genMode;
      cnt <= '0;
      state <= bus.genMode == 2'b00 ? RET : bus.genMode[1] ? HIGH : LOW;
      bus.theBit <= bus.genMode[1];
      bus.genDone <= 1'b0;
    end else if (state == IDLE || cnt == len_m1) begin
      state <= IDLE;
      cnt <= '0;
      bus.theBit <= 1'b0;
      bus.genDone <= 1'b0;
    end else begin
      cnt <= nxt;
      state <= state == RET ? RET : nxt < hi_len ? HIGH : LOW;
      bus.theBit <= nxt < hi_len;
      bus.genDone <= nxt == len_m1;
    end
endmodule

// File: tb/tb_ws2812b_bit_generator.sv
// tb_ws2812b_bit_generator: random and directed symbol requests checked cycle by cycle against a waveform queue model.
module tb_ws2812b_bit_generator;
  localparam int T0H = 40, T1H = 80, BITC = 125, RETC = 5000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  ws2812b_bit_generator_if bus();
  ws2812b_bit_generator dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] q[$];
  logic [1:0] exp_out = 2'b00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask
  // Each period becomes a list of {theBit, genDone} values, one per cycle.
  task automatic push_period(input logic [1:0] m);
    int len = m == 2'b00 ? RETC : BITC;
    int h = m == 2'b10 ? T0H : m == 2'b11 ? T1H : 0;
    for (int i = 0; i < len; i++) q.push_back({1'(i < h), 1'(i == len - 1)});
  endtask
  // An empty queue means idle or the final cycle of a period: the only times doGen is honoured.
  always @(posedge clk or posedge reset)
    if (reset) begin
      q.delete();
      exp_out = 2'b00;
    end else begin
      if (q.size() == 0 && bus.doGen) push_period(bus.genMode);
      exp_out = q.size() > 0 ? q.pop_front() : 2'b00;
    end
  task automatic step(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("wave", {30'd0, bus.theBit, bus.genDone}, {30'd0, exp_out});
      if (rnd) begin
        bus.genMode = $urandom_range(0, 15) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
        bus.doGen = $urandom_range(0, 3) != 0;
      end
    end
  endtask
  initial begin
    bus.genMode = 2'b00;
    bus.doGen = 1'b0;
    #4;
    check("rst_bit", {31'd0, bus.theBit}, 32'd0);
    check("rst_done", {31'd0, bus.genDone}, 32'd0);
    #6 reset = 1'b0;
    step(20, 0);
    check("idle_bit", {31'd0, bus.theBit}, 32'd0);
    bus.genMode = 2'b10;
    bus.doGen = 1'b1;
    step(3 * BITC, 0);
    bus.genMode = 2'b11;
    step(2 * BITC, 0);
    bus.genMode = 2'b00;
    step(1, 0);
    bus.genMode = 2'b10;
    bus.doGen = 1'b0;
    step(RETC + 20, 0);
    bus.genMode = 2'b01;
    bus.doGen = 1'b1;
    step(2 * BITC + 5, 0);
    bus.doGen = 1'b0;
    step(BITC, 0);
    bus.genMode = 2'b11;
    bus.doGen = 1'b1;
    step(60, 0);
    bus.doGen = 1'b0;
    step(2 * BITC, 0);
    check("idle_after_drop", {31'd0, bus.theBit}, 32'd0);
    bus.genMode = 2'b10;
    bus.doGen = 1'b1;
    step(20, 0);
    check("pre_rst_bit", {31'd0, bus.theBit}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_bit", {31'd0, bus.theBit}, 32'd0);
    check("midrst_done", {31'd0, bus.genDone}, 32'd0);
    step(2, 0);
    reset = 1'b0;
    step(BITC + 10, 0);
    step(30000, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
